// File: rtl/heichips25_result_collector.sv
// Result collector for the 4-bit systolic-array multiplier: FWFT FIFO with a valid/ready output, frame marking and a sticky overflow flag.
// Optional per-frame checksum word enabled by defining COLLECT_CHECKSUM_EN.
module heichips25_result_collector #(
  parameter int unsigned OUTWIDTH   = 8,
  parameter int unsigned FRAME_LEN  = 4,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [OUTWIDTH-1:0]           results,
  input  logic                          valid_out,
  input  logic                          clear,
  output logic [OUTWIDTH-1:0]           out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow
);

  localparam int unsigned PW  = $clog2(FIFO_DEPTH);
  localparam int unsigned LW  = PW + 1;
  localparam int unsigned FCW = $clog2(FRAME_LEN);
  localparam logic [FCW-1:0] FC_LAST  = FCW'(FRAME_LEN - 1);
  localparam logic [LW-1:0]  LVL_FULL = LW'(FIFO_DEPTH);

`ifdef COLLECT_CHECKSUM_EN
  typedef enum logic {STREAM, CKSUM} state_t;
  state_t              state, state_n;
  logic [OUTWIDTH-1:0] csum, csum_n;
`endif

  logic [OUTWIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr, wr_ptr_n, rd_ptr, rd_ptr_n;
  logic [FCW-1:0]      fcnt, fcnt_n;
  logic [LW-1:0]       level_n;
  logic                overflow_n, out_valid_n, out_last_n;
  logic [OUTWIDTH-1:0] out_data_n, head_n;
  logic                full, pop, push_ok, drop;

  // Next-state and next-output computation; outputs are registered from these.
  always_comb begin
    wr_ptr_n    = wr_ptr;
    rd_ptr_n    = rd_ptr;
    level_n     = level;
    fcnt_n      = fcnt;
    overflow_n  = overflow;
    out_valid_n = 1'b0;
    out_last_n  = 1'b0;
    out_data_n  = '0;
    full        = (level == LVL_FULL);
`ifdef COLLECT_CHECKSUM_EN
    state_n     = state;
    csum_n      = csum;
    pop         = (state == STREAM) && out_valid && out_ready;
`else
    pop         = out_valid && out_ready;
`endif
    push_ok     = valid_out && !clear && (!full || pop);
    drop        = valid_out && !clear && full && !pop;

    if (clear) begin
      wr_ptr_n   = '0;
      rd_ptr_n   = '0;
      level_n    = '0;
      fcnt_n     = '0;
      overflow_n = 1'b0;
`ifdef COLLECT_CHECKSUM_EN
      state_n    = STREAM;
      csum_n     = '0;
`endif
    end else begin
      if (push_ok) wr_ptr_n = wr_ptr + PW'(1);
      if (pop)     rd_ptr_n = rd_ptr + PW'(1);
      if (push_ok && !pop)      level_n = level + LW'(1);
      else if (pop && !push_ok) level_n = level - LW'(1);
      if (drop) overflow_n = 1'b1;
      if (pop)  fcnt_n = (fcnt == FC_LAST) ? '0 : fcnt + FCW'(1);
`ifdef COLLECT_CHECKSUM_EN
      if (pop) begin
        csum_n = csum + out_data;
        if (fcnt == FC_LAST) state_n = CKSUM;
      end
      if (state == CKSUM && out_ready) begin
        csum_n  = '0;
        state_n = STREAM;
      end
`endif
    end

    // Head after this edge, bypassing the word being written into an empty slot.
    head_n = (push_ok && (wr_ptr == rd_ptr_n)) ? results : mem[rd_ptr_n];

`ifdef COLLECT_CHECKSUM_EN
    if (state_n == CKSUM) begin
      out_valid_n = 1'b1;
      out_last_n  = 1'b1;
      out_data_n  = csum_n;
    end else begin
      out_valid_n = (level_n != '0);
      out_data_n  = head_n;
    end
`else
    out_valid_n = (level_n != '0);
    out_last_n  = out_valid_n && (fcnt_n == FC_LAST);
    out_data_n  = head_n;
`endif
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fcnt      <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
`ifdef COLLECT_CHECKSUM_EN
      state     <= STREAM;
      csum      <= '0;
`endif
    end else begin
      wr_ptr    <= wr_ptr_n;
      rd_ptr    <= rd_ptr_n;
      fcnt      <= fcnt_n;
      level     <= level_n;
      overflow  <= overflow_n;
      out_valid <= out_valid_n;
      out_last  <= out_last_n;
      out_data  <= out_data_n;
`ifdef COLLECT_CHECKSUM_EN
      state     <= state_n;
      csum      <= csum_n;
`endif
    end
  end

  // FIFO storage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= '0;
    end else if (push_ok) begin
      mem[wr_ptr] <= results;
    end
  end

endmodule

// File: tb/tb_heichips25_result_collector.sv
// Scoreboard bench for heichips25_result_collector (default build, FRAME_LEN=4, FIFO_DEPTH=8).
module tb_heichips25_result_collector;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] results;
  logic       valid_out;
  logic       clear;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic [3:0] level;
  logic       overflow;

  int tests = 0;
  int fails = 0;
  int acc_cnt = 0;
  logic [8:0] exp_q [$];

  heichips25_result_collector dut (
    .clk(clk), .reset(reset), .results(results), .valid_out(valid_out),
    .clear(clear), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .level(level),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one word for one edge; accepted words go to the scoreboard with their frame position.
  task automatic push_word(input logic [7:0] d, input bit accept);
    results   = d;
    valid_out = 1'b1;
    if (accept) begin
      exp_q.push_back({(acc_cnt % 4 == 3), d});
      acc_cnt++;
    end
    step();
    valid_out = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
    exp_q.delete();
    acc_cnt = 0;
  endtask

  // Monitor: every handshake must match the head of the scoreboard.
  always @(negedge clk) begin
    logic [8:0] e;
    if (!reset && out_valid && out_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL stream: unexpected word 0x%0h last=%0b", out_data, out_last);
      end else begin
        e = exp_q.pop_front();
        if ({out_last, out_data} !== e) begin
          fails++;
          $display("FAIL stream: got data 0x%0h last %0b expected data 0x%0h last %0b",
                   out_data, out_last, e[7:0], e[8]);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; results = '0; valid_out = 1'b0; clear = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset out_valid", 32'(out_valid), 0);
    chk("reset level", 32'(level), 0);
    chk("reset overflow", 32'(overflow), 0);
    chk("reset out_last", 32'(out_last), 0);
    chk("reset out_data", 32'(out_data), 0);

    // Single push, one-cycle latency
    step();
    push_word(8'h12, 1'b1);
    @(negedge clk);
    chk("single out_valid", 32'(out_valid), 1);
    chk("single out_data", 32'(out_data), 32'h12);
    chk("single level", 32'(level), 1);
    step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    @(negedge clk);
    chk("single drained level", 32'(level), 0);
    step();

    // Backpressure fill with one dropped word
    do_clear();
    for (int i = 1; i <= 8; i++) push_word(8'(i), 1'b1);
    push_word(8'h09, 1'b0);
    @(negedge clk);
    chk("fill level", 32'(level), 8);
    chk("fill overflow", 32'(overflow), 1);
    chk("fill out_data", 32'(out_data), 32'h01);
    step();
    out_ready = 1'b1;
    repeat (10) step();
    out_ready = 1'b0;
    @(negedge clk);
    chk("fill drained level", 32'(level), 0);
    chk("fill scoreboard empty", 32'(exp_q.size()), 0);
    step();

    // Push and pop together while full
    do_clear();
    for (int i = 1; i <= 8; i++) push_word(8'h20 + 8'(i), 1'b1);
    out_ready = 1'b1;
    push_word(8'h29, 1'b1);
    @(negedge clk);
    chk("full push+pop level", 32'(level), 8);
    chk("full push+pop overflow", 32'(overflow), 0);
    step();
    repeat (10) step();
    out_ready = 1'b0;
    @(negedge clk);
    chk("full drained level", 32'(level), 0);
    chk("full scoreboard empty", 32'(exp_q.size()), 0);
    step();

    // Frame marking with streaming consumer
    do_clear();
    out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) push_word(8'(i * 16), 1'b1);
    repeat (3) step();
    out_ready = 1'b0;
    @(negedge clk);
    chk("frame scoreboard empty", 32'(exp_q.size()), 0);
    step();

    // Clear with level=3, overflow=1, fcnt=2
    do_clear();
    for (int i = 1; i <= 8; i++) push_word(8'hB0 + 8'(i), 1'b1);
    push_word(8'hB9, 1'b0);
    out_ready = 1'b1;
    repeat (6) step();
    out_ready = 1'b0;
    push_word(8'hBA, 1'b1);
    @(negedge clk);
    chk("pre-clear level", 32'(level), 3);
    chk("pre-clear overflow", 32'(overflow), 1);
    step();
    results = 8'hEE;
    valid_out = 1'b1;
    do_clear();
    valid_out = 1'b0;
    @(negedge clk);
    chk("clear level", 32'(level), 0);
    chk("clear overflow", 32'(overflow), 0);
    chk("clear out_valid", 32'(out_valid), 0);
    chk("clear out_last", 32'(out_last), 0);
    step();
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) push_word(8'hC0 + 8'(i), 1'b1);
    repeat (3) step();
    out_ready = 1'b0;
    @(negedge clk);
    chk("post-clear scoreboard empty", 32'(exp_q.size()), 0);

    // Asynchronous reset between edges
    step();
    push_word(8'hD1, 1'b1);
    push_word(8'hD2, 1'b1);
    @(negedge clk);
    chk("pre-reset level", 32'(level), 2);
    #2 reset = 1'b1;
    #1;
    chk("async reset out_valid", 32'(out_valid), 0);
    chk("async reset level", 32'(level), 0);
    chk("async reset out_data", 32'(out_data), 0);
    exp_q.delete();
    acc_cnt = 0;
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) step();
    chk("post-reset out_valid", 32'(out_valid), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
